// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer.
//   st_e      : sequencer FSM state encoding (2 bits)
//   npc_sel_e : next-PC select codes fed to pc_next_calc
//   PC_W / OFF_W / JT_W : program counter, branch offset and jump target widths
package pc_seq_pkg;

  localparam int PC_W  = 32;
  localparam int OFF_W = 16;
  localparam int JT_W  = 26;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } st_e;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_HOLD   = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch handshake.
//   imem_req  : fetch request, held high until acknowledged
//   imem_addr : word address being fetched
//   imem_ack  : memory accepted/returned the instruction this cycle
// master = sequencer side, slave = memory side.
interface pc_fetch_sequencer_if;
  import pc_seq_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input  imem_ack);
  modport slave  (input  imem_req, input  imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_sequencer_next_calc.sv
// Combinational next-PC generator.
//   pc      : current program counter
//   sel     : SEQ (pc+1), BRANCH (pc+1+sext(offset)), JUMP ({pc[31:26],target}), HOLD (pc)
//   offset  : signed word offset for branches
//   target  : word index for absolute jumps
//   pc_next : selected next program counter (all arithmetic modulo 2^32)
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0]         pc,
  input  npc_sel_e                sel,
  input  logic signed [OFF_W-1:0] offset,
  input  logic [JT_W-1:0]         target,
  output logic [PC_W-1:0]         pc_next
);

  logic [PC_W-1:0]        pc_inc;
  logic signed [PC_W-1:0] off_ext;

  always_comb begin
    pc_inc  = pc + 32'd1;
    off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    pc_next = pc_inc;
    unique case (sel)
      NPC_SEQ:    pc_next = pc_inc;
      // Two's complement add of the extended offset gives the wrap below 0.
      NPC_BRANCH: pc_next = pc_inc + $unsigned(off_ext);
      NPC_JUMP:   pc_next = {pc[PC_W-1:JT_W], target};
      NPC_HOLD:   pc_next = pc;
      default:    pc_next = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and fetch sequencer for the single-cycle CPU.
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem           : fetch handshake (master side)
//   instr_valid    : instruction at pc ready, held through EXEC
//   exec_done      : core finished instruction at pc (sampled in EXEC only)
//   branch_taken / branch_offset, jump_en / jump_target, halt_req : next-PC controls
//   pc, halted, fetch_err (sticky watchdog expiry), retired (accepted exec_done count)
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_ADDR    = 32'h0000_0000,
  parameter int unsigned     FETCH_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pc_fetch_sequencer_if.master     imem,
  output logic                     instr_valid,
  input  logic                     exec_done,
  input  logic                     branch_taken,
  input  logic signed [OFF_W-1:0]  branch_offset,
  input  logic                     jump_en,
  input  logic [JT_W-1:0]          jump_target,
  input  logic                     halt_req,
  output logic [PC_W-1:0]          pc,
  output logic                     halted,
  output logic                     fetch_err,
  output logic [PC_W-1:0]          retired
);

  localparam logic [7:0] TIMEOUT = 8'(FETCH_TIMEOUT);

  st_e             state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] retired_q, retired_d;
  logic [7:0]      wdog_q, wdog_d;
  logic            fetch_err_q, fetch_err_d;

  npc_sel_e        npc_sel;
  logic [PC_W-1:0] pc_next;

  // Priority: halt > jump > branch > sequential.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (halt_req)          npc_sel = NPC_HOLD;
    else if (jump_en)      npc_sel = NPC_JUMP;
    else if (branch_taken) npc_sel = NPC_BRANCH;
  end

  pc_next_calc u_next (
    .pc      (pc_q),
    .sel     (npc_sel),
    .offset  (branch_offset),
    .target  (jump_target),
    .pc_next (pc_next)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    wdog_d      = wdog_q;
    fetch_err_d = fetch_err_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        wdog_d  = 8'd0;
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          state_d = ST_EXEC;
          wdog_d  = 8'd0;
        end else begin
          wdog_d = wdog_q + 8'd1;
          // The cycle that makes the count reach the limit is the last FETCH cycle.
          if (wdog_q + 8'd1 == TIMEOUT) begin
            state_d     = ST_HALTED;
            fetch_err_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + 32'd1;
          pc_d      = pc_next;
          wdog_d    = 8'd0;
          state_d   = halt_req ? ST_HALTED : ST_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_ADDR;
      retired_q   <= '0;
      wdog_q      <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      wdog_q      <= wdog_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == ST_EXEC);
  assign halted         = (state_q == ST_HALTED);
  assign fetch_err      = fetch_err_q;
  assign pc             = pc_q;
  assign retired        = retired_q;

endmodule
